// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package bit_serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : bit_serial_adder_pkg

// File: rtl/bit_serial_adder_fa.sv
// One-bit full adder cell built from two half-adder stages plus an OR
// that merges the two stage carries into the carry-out.
module full_adder_cell (
  input  logic i_data_a,
  input  logic i_data_b,
  input  logic i_carry,
  output logic o_data,
  output logic o_carry
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder combines the operand bits, second folds in the carry.
  assign ha0_sum   = i_data_a ^ i_data_b;
  assign ha0_carry = i_data_a & i_data_b;
  assign o_data    = ha0_sum ^ i_carry;
  assign ha1_carry = ha0_sum & i_carry;
  assign o_carry   = ha0_carry | ha1_carry;

endmodule : full_adder_cell

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one full-adder cell, registered carry, WIDTH+1 cycle latency.
// Optional subtraction (i_sub port) is enabled by defining BIT_SERIAL_ADDER_SUB_EN.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_carry;
  logic             accept_sub;
  logic [WIDTH-1:0] accept_b;

`ifdef BIT_SERIAL_ADDER_SUB_EN
  assign accept_sub = i_sub;
`else
  assign accept_sub = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
  assign accept_b = i_data_b ^ {WIDTH{accept_sub}};

  full_adder_cell u_fa (
    .i_data_a (a_q[0]),
    .i_data_b (b_q[0]),
    .i_carry  (carry_q),
    .o_data   (fa_sum),
    .o_carry  (fa_carry)
  );

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_data_a;
          b_d     = accept_b;
          carry_d = accept_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB during the last bit.
          ovf_d   = carry_q ^ fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshakes are masked during reset so nothing is offered or accepted.
  assign o_ready    = (state_q == IDLE) && !i_rst;
  assign o_valid    = (state_q == DONE) && !i_rst;
  assign o_sum      = res_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;

endmodule : bit_serial_adder
